uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Configurable UART receiver for the peripheral subsystem.
- Supports 5–8 data bits, optional even/odd parity, and 1 or 2 stop bits.
- Uses 3-sample majority voting and validates the start bit.
- Reports framing, parity and break errors per character.
- Buffers received characters with their flags in a first-word-fall-through FIFO read by the bus-side register interface.

Parameters:
DIV_W, 16, width of the divider port. Bit period = divider+1 clk cycles.
FIFO_DEPTH, 8, number of FIFO entries. Must be a power of two and ≥2.
TIMEOUT_BITS, 32, idle bit periods before rx_timeout asserts. Used only with the optional feature.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous, active-low reset
divider  in  DIV_W  clk cycles per bit minus 1; must be ≥3; held stable while a frame is in progress
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity_en  in  1  parity bit present
cfg_parity_odd  in  1  1=odd parity, 0=even parity
cfg_stop2  in  1  two stop bits
uart_rx_en  in  1  receiver enable; gates only the detection of new start bits
uart_rxd  in  1  asynchronous serial input
rd_en  in  1  pop the FIFO head
rd_valid  out  1  FIFO not empty
rd_data  out  8  head data, LSB-first assembled, right-aligned, unused upper bits 0
rd_frame_err  out  1  head character had a stop bit sampled 0
rd_parity_err  out  1  head character had a parity mismatch
rd_break  out  1  head character is a break
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
overrun  out  1  sticky flag: a character was dropped because the FIFO was full
clr_overrun  in  1  clears overrun
rx_timeout  out  1  character-timeout indication (optional feature)

Behaviour:
- Reset values:
  - 2-flop synchronizer on uart_rxd resets to 1.
  - FSM in IDLE, FIFO empty, overrun=0, rx_timeout=0.
  - rd_* outputs are 0.
  - Reset mid-frame discards the partial character and the FIFO contents.
- Bit timing:
  - Counter runs 0..divider, then wraps to 0 and advances to the next bit.
  - mid = divider>>1. The line (after the synchronizer) is sampled at counts mid-1, mid and mid+1.
  - The bit value is the majority of the 3 samples, resolved at count mid+1.
- FSM states and transitions:
  - IDLE: on synchronized line = 0 and uart_rx_en=1, enter START with count=0.
  - START: voted value 1 → false start; return to IDLE and push nothing. Voted value 0 → continue to DATA at the period boundary.
  - DATA: receive N bits, LSB first → PARITY if cfg_parity_en, else STOP.
  - PARITY: parity_err = (XOR of data bits ^ parity bit) != 0 for even parity; for odd parity, parity_err is set if the XOR is 0.
  - STOP:
    - Stop bit 1 is sampled. With cfg_stop2, both stop bits are sampled and frame_err = either is 0.
    - The character is pushed on the cycle the final stop vote resolves (count mid+1). The FSM then goes to IDLE, giving a half-bit early resync.
    - rd_valid rises on the following cycle.
  - BRK_WAIT:
    - Entered instead of IDLE when break = data all 0, parity bit 0 (if enabled), and the final stop bit 0.
    - The break entry has frame_err=1 and parity_err per its rule.
    - Returns to IDLE only after the synchronized line reads 1. Exactly one entry is produced per break regardless of its length.
- Deasserting uart_rx_en mid-frame lets the frame complete. The config inputs are sampled once at start-bit acceptance.
- FIFO:
  - Push when full drops the new entry and sets overrun. The stored head is unchanged.
  - Pop with rd_en && rd_valid. rd_en while empty is ignored.
  - Push and pop in the same cycle when full: both succeed, no overrun, level unchanged.
  - Push and pop in the same cycle when empty: the entry is pushed; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level reaches FIFO_DEPTH when full.
- overrun: clr_overrun has priority over a simultaneous set.

Optional Feature:
UART_RX_TIMEOUT_EN:
- When defined:
  - A bit-period counter counts while the FIFO is non-empty and the FSM is in IDLE.
  - rx_timeout asserts after TIMEOUT_BITS consecutive idle bit periods.
  - Any pop, any start-bit acceptance, or a reset clears rx_timeout and the counter.
- When undefined: rx_timeout is tied to 0 and no counter logic exists.

Test Plan:
- 8N1, divider=15, send 0xA5 → one entry, rd_data=0xA5, all flags 0, level=1; rd_en → rd_valid=0.
- 7E1, send 0x41 with parity bit 1 → rd_data=0x41, parity_err=1. Same frame 7O1 → parity_err=0. 5N2 with 0x1F → rd_data=0x1F.
- 8N1, 0x55 with stop bit 0 → frame_err=1, break=0. Line low for 12 bit periods → exactly one entry: data 0x00, break=1, frame_err=1. A next entry appears only after the line returns high and a new frame is sent.
- Glitch tests at divider=15:
  - 3-cycle low pulse on an idle line → no entry.
  - One sample flipped at count mid-1 in each data bit of 0x3C → rd_data=0x3C.
- FIFO_DEPTH=8, send 9 bytes 0x01..0x09 without popping → level=8, overrun=1, head=0x01.
- Push-on-full: pop on the exact push cycle of a 9th byte → no overrun, level stays 8. clr_overrun → overrun=0.
- Timeout (with UART_RX_TIMEOUT_EN, TIMEOUT_BITS=32): 1 byte then idle → rx_timeout rises after 32 bit periods (32×16 cycles); pop → rx_timeout=0. resetn low mid-frame → level=0, no entry.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus-side read port of uart_rx_fifo: FIFO head with per-character flags, pop strobe and status.
// The master is the register interface; the slave is the receiver.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_frame_err;
  logic             rd_parity_err;
  logic             rd_break;
  logic [LVL_W-1:0] fifo_level;
  logic             overrun;
  logic             clr_overrun;
  logic             rx_timeout;

  modport master (
    output rd_en, clr_overrun,
    input  rd_valid, rd_data, rd_frame_err, rd_parity_err, rd_break,
           fifo_level, overrun, rx_timeout
  );

  modport slave (
    input  rd_en, clr_overrun,
    output rd_valid, rd_data, rd_frame_err, rd_parity_err, rd_break,
           fifo_level, overrun, rx_timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-8 data bits, optional parity, 1/2 stop bits, 3-sample vote) feeding a FWFT FIFO.
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] divider,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  input  logic             uart_rx_en,
  input  logic             uart_rxd,
  uart_rx_fifo_if.slave    bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;

  typedef struct packed {
    logic       brk;
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } entry_t;

  logic             rxd_meta_q, rxd_sync_q;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             stop1_q, stop1_d;
  logic             stop_idx_q, stop_idx_d;
  logic [1:0]       cfg_bits_q, cfg_bits_d;
  logic             cfg_par_en_q, cfg_par_en_d;
  logic             cfg_par_odd_q, cfg_par_odd_d;
  logic             cfg_stop2_q, cfg_stop2_d;

  logic             line, vote, running, is_break;
  logic             at_m1, at_mid, at_p1, at_end;
  logic [DIV_W-1:0] mid;
  logic [2:0]       last_bit;
  logic             push;
  entry_t           push_entry;

  assign line     = rxd_sync_q;
  assign mid      = divider >> 1;
  assign at_m1    = (cnt_q == mid - DIV_W'(1));
  assign at_mid   = (cnt_q == mid);
  assign at_p1    = (cnt_q == mid + DIV_W'(1));
  assign at_end   = (cnt_q == divider);
  assign running  = state_q inside {START, DATA, PARITY, STOP};
  assign last_bit = {1'b1, cfg_bits_q};
  // The third sample is the live line at mid+1, so the vote resolves on that same cycle.
  assign vote     = (samp_q[0] & samp_q[1]) | (line & (samp_q[0] | samp_q[1]));
  assign is_break = (shift_q == 8'h00) && !(cfg_par_en_q && par_bit_q) && !vote;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    samp_d        = samp_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    stop1_d       = stop1_q;
    stop_idx_d    = stop_idx_q;
    cfg_bits_d    = cfg_bits_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_odd_d = cfg_par_odd_q;
    cfg_stop2_d   = cfg_stop2_q;
    push          = 1'b0;
    push_entry    = '0;

    if (running) begin
      cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
      if (at_m1)  samp_d[0] = line;
      if (at_mid) samp_d[1] = line;
    end

    unique case (state_q)
      IDLE: begin
        if (!line && uart_rx_en) begin
          state_d       = START;
          cnt_d         = '0;
          bit_idx_d     = '0;
          shift_d       = '0;
          par_bit_d     = 1'b0;
          stop1_d       = 1'b1;
          stop_idx_d    = 1'b0;
          cfg_bits_d    = cfg_data_bits;
          cfg_par_en_d  = cfg_parity_en;
          cfg_par_odd_d = cfg_parity_odd;
          cfg_stop2_d   = cfg_stop2;
        end
      end
      START: begin
        if (at_p1 && vote) state_d = IDLE;
        else if (at_end)   state_d = DATA;
      end
      DATA: begin
        if (at_p1) shift_d[bit_idx_q] = vote;
        if (at_end) begin
          if (bit_idx_q == last_bit) state_d = cfg_par_en_q ? PARITY : STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (at_p1)  par_bit_d = vote;
        if (at_end) state_d = STOP;
      end
      STOP: begin
        if (at_p1) begin
          if (cfg_stop2_q && !stop_idx_q) begin
            stop1_d = vote;
          end else begin
            push            = 1'b1;
            push_entry.data = shift_q;
            push_entry.ferr = !vote || !stop1_q;
            push_entry.perr = cfg_par_en_q && ((^shift_q ^ par_bit_q) ^ cfg_par_odd_q);
            push_entry.brk  = is_break;
            state_d         = is_break ? BRK_WAIT : IDLE;
          end
        end else if (at_end) begin
          stop_idx_d = 1'b1;
        end
      end
      BRK_WAIT: if (line) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FIFO: entries are stored with their flags; head is forced to 0 while empty.
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             rd_valid, full, pop, wr_en;
  entry_t           head;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == LVL_W'(FIFO_DEPTH));
  assign pop      = bus.rd_en && rd_valid;
  assign wr_en    = push && (!full || pop);
  assign head     = rd_valid ? fifo_mem[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + LVL_W'(wr_en) - LVL_W'(pop);
    overrun_d = overrun_q;
    if (bus.clr_overrun)    overrun_d = 1'b0;
    else if (push && !wr_en) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state flops use <= so every flop sees pre-edge values.
    if (!resetn) begin
      rxd_meta_q    <= 1'b1;
      rxd_sync_q    <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      samp_q        <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      stop1_q       <= 1'b1;
      stop_idx_q    <= 1'b0;
      cfg_bits_q    <= '0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_odd_q <= 1'b0;
      cfg_stop2_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      rxd_meta_q    <= uart_rxd;
      rxd_sync_q    <= rxd_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      samp_q        <= samp_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      stop1_q       <= stop1_d;
      stop_idx_q    <= stop_idx_d;
      cfg_bits_q    <= cfg_bits_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_odd_q <= cfg_par_odd_d;
      cfg_stop2_q   <= cfg_stop2_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overrun_q     <= overrun_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign bus.rd_valid      = rd_valid;
  assign bus.rd_data       = head.data;
  assign bus.rd_frame_err  = head.ferr;
  assign bus.rd_parity_err = head.perr;
  assign bus.rd_break      = head.brk;
  assign bus.fifo_level    = count_q;
  assign bus.overrun       = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TB_W = $clog2(TIMEOUT_BITS + 1);

  logic [DIV_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TB_W-1:0]  tmo_bits_q, tmo_bits_d;
  logic             rx_timeout_q, rx_timeout_d;
  logic             start_acc;

  assign start_acc = (state_q == IDLE) && !line && uart_rx_en;

  // Counts whole idle bit periods while data waits; any interruption restarts the count.
  always_comb begin
    tmo_cnt_d    = '0;
    tmo_bits_d   = '0;
    rx_timeout_d = rx_timeout_q;
    if (pop || start_acc) begin
      rx_timeout_d = 1'b0;
    end else if (rd_valid && state_q == IDLE) begin
      tmo_bits_d = tmo_bits_q;
      if (tmo_cnt_q != divider)                          tmo_cnt_d = tmo_cnt_q + DIV_W'(1);
      else if (tmo_bits_q == TB_W'(TIMEOUT_BITS - 1))    rx_timeout_d = 1'b1;
      else                                               tmo_bits_d = tmo_bits_q + TB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_q    <= '0;
      tmo_bits_q   <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_bits_q   <= tmo_bits_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign bus.rx_timeout = rx_timeout_q;
`else
  assign bus.rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected FIFO entries, a monitor checks every pop.
// Bit period is 16 clocks (divider=15); serial input is driven on falling clock edges.
module tb_uart_rx_fifo;
  localparam int DIV_W        = 16;
  localparam int FIFO_DEPTH   = 8;
  localparam int TIMEOUT_BITS = 32;
  localparam int P            = 16;
  // Negedges from frame start to the cycle in which an 8N1 character is pushed.
  localparam int PUSH_NEG     = 156;
`ifdef UART_RX_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [DIV_W-1:0] divider = DIV_W'(15);
  logic [1:0]       cfg_data_bits = 2'b11;
  logic             cfg_parity_en = 1'b0;
  logic             cfg_parity_odd = 1'b0;
  logic             cfg_stop2 = 1'b0;
  logic             uart_rx_en = 1'b1;
  logic             uart_rxd = 1'b1;
  logic             mon_pop = 1'b0;
  logic             man_pop = 1'b0;
  logic             auto_pop = 1'b0;
  logic             clr = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] exp_q [$];

  uart_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();
  assign bus.rd_en       = mon_pop | man_pop;
  assign bus.clr_overrun = clr;

  uart_rx_fifo #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .divider        (divider),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .uart_rx_en     (uart_rx_en),
    .uart_rxd       (uart_rxd),
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [7:0] data, input logic ferr, input logic perr, input logic brk);
    exp_q.push_back({brk, perr, ferr, data});
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    for (int s = 0; s < P; s++) begin
      uart_rxd = (glitch && s == 7) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_val, input int nstop, input logic stop_val,
                            input logic glitch);
    @(negedge clk);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i], glitch);
    if (par_en) send_bit(par_val, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(stop_val, 1'b0);
    uart_rxd = 1'b1;
    repeat (2 * P) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compares the head against the scoreboard whenever a real pop happens.
  initial begin
    forever begin
      @(negedge clk);
      mon_pop = auto_pop && bus.rd_valid;
      #1;
      if (bus.rd_en && bus.rd_valid) begin
        check("sb_entry_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("sb_head", {bus.rd_break, bus.rd_parity_err, bus.rd_frame_err, bus.rd_data},
                exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_flags", {bus.rd_data, bus.rd_frame_err, bus.rd_parity_err, bus.rd_break}, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_timeout", bus.rx_timeout, 0);
    resetn = 1'b1;
    repeat (P) @(negedge clk);

    // 8N1 0xA5, inspected in place before popping
    expect_entry(8'hA5, 0, 0, 0);
    send_frame(8'hA5, 8, 0, 0, 1, 1'b1, 0);
    check("a5_level", bus.fifo_level, 1);
    check("a5_head", {bus.rd_break, bus.rd_parity_err, bus.rd_frame_err, bus.rd_data}, 11'h0A5);
    auto_pop = 1'b1;
    repeat (4) @(negedge clk);
    check("a5_popped_valid", bus.rd_valid, 0);

    auto_pop = 1'b0;
    man_pop  = 1'b1;
    @(negedge clk);
    man_pop  = 1'b0;
    @(negedge clk);
    check("pop_empty_level", bus.fifo_level, 0);
    auto_pop = 1'b1;

    // 7E1 / 7O1 with 0x41 and parity bit 1, then 5N2 0x1F
    cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    expect_entry(8'h41, 0, 1, 0);
    send_frame(8'h41, 7, 1, 1'b1, 1, 1'b1, 0);
    cfg_parity_odd = 1'b1;
    expect_entry(8'h41, 0, 0, 0);
    send_frame(8'h41, 7, 1, 1'b1, 1, 1'b1, 0);
    cfg_data_bits = 2'b00; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    expect_entry(8'h1F, 0, 0, 0);
    send_frame(8'h1F, 5, 0, 0, 2, 1'b1, 0);
    cfg_data_bits = 2'b11; cfg_stop2 = 1'b0;
    drain("fmt_drained");

    // Framing error without break, then a 12-bit-period break
    expect_entry(8'h55, 1, 0, 0);
    send_frame(8'h55, 8, 0, 0, 1, 1'b0, 0);
    drain("ferr_drained");
    auto_pop = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (12 * P) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("brk_level", bus.fifo_level, 1);
    check("brk_head", {bus.rd_break, bus.rd_parity_err, bus.rd_frame_err, bus.rd_data}, 11'h500);
    expect_entry(8'h00, 1, 0, 1);
    auto_pop = 1'b1;
    expect_entry(8'h33, 0, 0, 0);
    send_frame(8'h33, 8, 0, 0, 1, 1'b1, 0);
    drain("brk_drained");

    // Glitches: short low pulse, then one flipped sample per data bit
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("pulse_level", bus.fifo_level, 0);
    expect_entry(8'h3C, 0, 0, 0);
    send_frame(8'h3C, 8, 0, 0, 1, 1'b1, 1);
    drain("glitch_drained");

    // Receiver disabled: a whole frame is ignored
    uart_rx_en = 1'b0;
    send_frame(8'h11, 8, 0, 0, 1, 1'b1, 0);
    uart_rx_en = 1'b1;
    check("rxen_off_level", bus.fifo_level, 0);

    // Pop on the push cycle while empty: entry lands, pop ignored
    auto_pop = 1'b0;
    expect_entry(8'h5A, 0, 0, 0);
    fork
      send_frame(8'h5A, 8, 0, 0, 1, 1'b1, 0);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
      end
    join
    check("empty_pushpop_level", bus.fifo_level, 1);
    auto_pop = 1'b1;
    drain("empty_pushpop_drained");

    // Fill past full: 0x09 is dropped
    auto_pop = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) expect_entry(8'(i), 0, 0, 0);
      send_frame(8'(i), 8, 0, 0, 1, 1'b1, 0);
    end
    check("full_level", bus.fifo_level, 8);
    check("full_overrun", bus.overrun, 1);
    check("full_head", bus.rd_data, 8'h01);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_overrun", bus.overrun, 0);

    // Pop on the exact push cycle while full
    expect_entry(8'h0A, 0, 0, 0);
    fork
      send_frame(8'h0A, 8, 0, 0, 1, 1'b1, 0);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
        check("full_pushpop_level", bus.fifo_level, 8);
      end
    join
    check("full_pushpop_overrun", bus.overrun, 0);
    check("full_pushpop_head", bus.rd_data, 8'h02);
    auto_pop = 1'b1;
    drain("full_drained");

    // Character timeout: ~512 clocks after the push
    auto_pop = 1'b0;
    expect_entry(8'h42, 0, 0, 0);
    send_frame(8'h42, 8, 0, 0, 1, 1'b1, 0);
    repeat (29 * P) @(negedge clk);
    check("tmo_early", bus.rx_timeout, 0);
    repeat (2 * P) @(negedge clk);
    check("tmo_set", bus.rx_timeout, 32'(TMO_EXP));
    man_pop = 1'b1;
    @(negedge clk);
    man_pop = 1'b0;
    @(negedge clk);
    check("tmo_cleared", bus.rx_timeout, 0);
    check("tmo_popped_level", bus.fifo_level, 0);

    // Reset mid-frame discards the partial character and the FIFO
    send_frame(8'h77, 8, 0, 0, 1, 1'b1, 0);
    check("prerst_level", bus.fifo_level, 1);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3 * P) @(negedge clk);
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    resetn   = 1'b1;
    repeat (12 * P) @(negedge clk);
    check("midrst_level", bus.fifo_level, 0);
    check("midrst_head", {bus.rd_valid, bus.rd_data, bus.rd_frame_err, bus.rd_break}, 0);
    check("midrst_overrun", bus.overrun, 0);

    check("sb_all_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
